// File: rtl/irq_trap_sequencer.sv
// -----------------------------------------------------------------------------
// irq_trap_sequencer
//
// Machine-mode interrupt sequencer for the 3-stage RV32I core
// (fetch / decode-execute / memory-writeback).
//
// It owns the free-running mtime counter and the mtimecmp register. It also
// synchronises the asynchronous external interrupt line. When an enabled
// source is pending, it waits for a safe decode-execute slot and then issues
// a one-cycle trap-entry strobe. The strobe carries mcause/mepc to the CSR
// file. In the same cycle it flushes IR_D and releases the fetch hold. The
// handler is treated as in progress until an mret retires.
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-high reset
//   ext_irq      raw external interrupt (level, asynchronous to clk)
//   mstatus_mie  global interrupt enable
//   mie_meie     external interrupt enable
//   mie_mtie     timer interrupt enable
//   cmp_wr       mtimecmp write strobe
//   cmp_wdata    mtimecmp write data
//   pc_d         PC of the instruction in decode-execute
//   valid_d      decode-execute holds a real instruction
//   stall        hazard-unit stall this cycle
//   br_taken     branch/jump redirect this cycle
//   mret_e       mret in memory-writeback this cycle
//   intr_req     one-cycle trap-entry strobe
//   intr_cause   mcause value (valid while intr_req=1, else 0)
//   epc          mepc value (valid while intr_req=1, else 0)
//   flush        zero IR_D this cycle
//   hold_fetch   freeze PC / IR_D update
//   irq_active   handler in progress
//   mtime        current timer value
//
// All control outputs are decoded only from registered state, so they carry
// no combinational path from the inputs.
// -----------------------------------------------------------------------------
module irq_trap_sequencer #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] CMP_RESET   = 32'hFFFF_FFFF,
    parameter logic [31:0] CAUSE_EXT   = 32'h8000_000B,
    parameter logic [31:0] CAUSE_TMR   = 32'h8000_0007,
    // mtime starting value after reset.
    parameter logic [31:0] MTIME_INIT  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic        mie_meie,
    input  logic        mie_mtie,
    input  logic        cmp_wr,
    input  logic [31:0] cmp_wdata,
    input  logic [31:0] pc_d,
    input  logic        valid_d,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        mret_e,
    output logic        intr_req,
    output logic [31:0] intr_cause,
    output logic [31:0] epc,
    output logic        flush,
    output logic        hold_fetch,
    output logic        irq_active,
    output logic [31:0] mtime
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SLOT = 2'd1,
        TRAP      = 2'd2,
        HANDLER   = 2'd3
    } state_t;

    // External interrupt wins over the timer when both are taken together.
    function automatic logic [31:0] select_cause(input logic ext_sel);
        logic [31:0] cause_v;
        if (ext_sel) begin
            cause_v = CAUSE_EXT;
        end else begin
            cause_v = CAUSE_TMR;
        end
        return cause_v;
    endfunction

    state_t                 state_r;
    state_t                 state_s;
    logic [31:0]            mtime_r;
    logic [31:0]            mtimecmp_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic [31:0]            cause_r;
    logic [31:0]            epc_r;

    logic                   tmr_pend_s;
    logic                   ext_pend_s;
    logic                   take_ext_s;
    logic                   take_tmr_s;
    logic                   any_s;
    logic                   slot_ok_s;
    logic                   latch_s;

    logic                   intr_req_s;
    logic                   flush_s;
    logic                   hold_fetch_s;
    logic                   irq_active_s;
    logic [31:0]            intr_cause_s;
    logic [31:0]            epc_s;

    // Pending / enable qualification and safe-slot detection.
    assign tmr_pend_s = (mtime_r >= mtimecmp_r);
    assign ext_pend_s = sync_r[SYNC_STAGES-1];
    assign take_ext_s = ext_pend_s & mie_meie & mstatus_mie;
    assign take_tmr_s = tmr_pend_s & mie_mtie & mstatus_mie;
    assign any_s      = take_ext_s | take_tmr_s;
    assign slot_ok_s  = valid_d & ~stall & ~br_taken;

    // Free-running machine timer; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_r <= MTIME_INIT;
        end else begin
            mtime_r <= mtime_r + 32'd1;
        end
    end

    // mtimecmp register; a write takes effect for the compare from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtimecmp_r <= CMP_RESET;
        end else if (cmp_wr) begin
            mtimecmp_r <= cmp_wdata;
        end else begin
            mtimecmp_r <= mtimecmp_r;
        end
    end

    // Multi-flop synchroniser for the asynchronous external interrupt line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], ext_irq};
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Cause/epc capture at the moment the trap is committed. The values are
    // frozen through TRAP and HANDLER even if the sources change.
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_r <= 32'h0000_0000;
            epc_r   <= 32'h0000_0000;
        end else if (latch_s) begin
            cause_r <= select_cause(take_ext_s);
            epc_r   <= pc_d;
        end else begin
            cause_r <= cause_r;
            epc_r   <= epc_r;
        end
    end

    // Next-state logic and Moore output decode from the registered state.
    always_comb begin
        state_s      = state_r;
        latch_s      = 1'b0;
        intr_req_s   = 1'b0;
        flush_s      = 1'b0;
        hold_fetch_s = 1'b0;
        irq_active_s = 1'b0;
        intr_cause_s = 32'h0000_0000;
        epc_s        = 32'h0000_0000;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_s = WAIT_SLOT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_SLOT: begin
                hold_fetch_s = 1'b1;
                // If the source is withdrawn or disabled before a slot opens, no trap is taken.
                if (!any_s) begin
                    state_s = IDLE;
                end else if (slot_ok_s) begin
                    state_s = TRAP;
                    latch_s = 1'b1;
                end else begin
                    state_s = WAIT_SLOT;
                end
            end
            TRAP: begin
                intr_req_s   = 1'b1;
                flush_s      = 1'b1;
                intr_cause_s = cause_r;
                epc_s        = epc_r;
                state_s      = HANDLER;
            end
            HANDLER: begin
                irq_active_s = 1'b1;
                // No nesting. Any pending source is re-evaluated only after
                // returning to IDLE, so there is at least one IDLE cycle
                // between handlers.
                if (mret_e) begin
                    state_s = IDLE;
                end else begin
                    state_s = HANDLER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign intr_req   = intr_req_s;
    assign flush      = flush_s;
    assign hold_fetch = hold_fetch_s;
    assign irq_active = irq_active_s;
    assign intr_cause = intr_cause_s;
    assign epc        = epc_s;
    assign mtime      = mtime_r;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_trap_sequencer
//
// Directed testbench for irq_trap_sequencer. The expected values are worked
// out by hand from the sequencer's behaviour. A second instance starts mtime
// just below the wrap point so the unsigned compare can be exercised across
// the 32'hFFFF_FFFF -> 0 wrap.
// -----------------------------------------------------------------------------
module tb_irq_trap_sequencer;

    logic        clk;
    logic        reset;
    logic        ext_irq;
    logic        mstatus_mie;
    logic        mie_meie;
    logic        mie_mtie;
    logic        cmp_wr;
    logic [31:0] cmp_wdata;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        stall;
    logic        br_taken;
    logic        mret_e;
    logic        intr_req;
    logic [31:0] intr_cause;
    logic [31:0] epc;
    logic        flush;
    logic        hold_fetch;
    logic        irq_active;
    logic [31:0] mtime;

    logic        w_reset;
    logic        w_cmp_wr;
    logic [31:0] w_cmp_wdata;
    logic        w_intr_req;
    logic [31:0] w_intr_cause;
    logic [31:0] w_epc;
    logic        w_flush;
    logic        w_hold_fetch;
    logic        w_irq_active;
    logic [31:0] w_mtime;

    int checks;
    int errors;

    irq_trap_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .ext_irq    (ext_irq),
        .mstatus_mie(mstatus_mie),
        .mie_meie   (mie_meie),
        .mie_mtie   (mie_mtie),
        .cmp_wr     (cmp_wr),
        .cmp_wdata  (cmp_wdata),
        .pc_d       (pc_d),
        .valid_d    (valid_d),
        .stall      (stall),
        .br_taken   (br_taken),
        .mret_e     (mret_e),
        .intr_req   (intr_req),
        .intr_cause (intr_cause),
        .epc        (epc),
        .flush      (flush),
        .hold_fetch (hold_fetch),
        .irq_active (irq_active),
        .mtime      (mtime)
    );

    irq_trap_sequencer #(.MTIME_INIT(32'hFFFF_FFFC)) u_wrap (
        .clk        (clk),
        .reset      (w_reset),
        .ext_irq    (1'b0),
        .mstatus_mie(1'b1),
        .mie_meie   (1'b0),
        .mie_mtie   (1'b1),
        .cmp_wr     (w_cmp_wr),
        .cmp_wdata  (w_cmp_wdata),
        .pc_d       (32'h0000_0000),
        .valid_d    (1'b0),
        .stall      (1'b0),
        .br_taken   (1'b0),
        .mret_e     (1'b0),
        .intr_req   (w_intr_req),
        .intr_cause (w_intr_cause),
        .epc        (w_epc),
        .flush      (w_flush),
        .hold_fetch (w_hold_fetch),
        .irq_active (w_irq_active),
        .mtime      (w_mtime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Close the running handler cleanly: disable everything, let the
    // synchroniser drain, then retire mret.
    task automatic finish_handler();
        mstatus_mie = 1'b0;
        ext_irq     = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("fh_active_before_mret", irq_active, 1'b1);
        mret_e = 1'b1;
        tick();
        mret_e = 1'b0;
        check("fh_active_after_mret", irq_active, 1'b0);
        tick();
        check("fh_hold_idle", hold_fetch, 1'b0);
        check("fh_req_idle", intr_req, 1'b0);
    endtask

    logic exp_hold [8];

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        w_reset     = 1'b1;
        w_cmp_wr    = 1'b0;
        w_cmp_wdata = 32'h0000_0000;
        ext_irq     = 1'b0;
        mstatus_mie = 1'b0;
        mie_meie    = 1'b0;
        mie_mtie    = 1'b0;
        cmp_wr      = 1'b0;
        cmp_wdata   = 32'h0000_0000;
        pc_d        = 32'h0000_0000;
        valid_d     = 1'b0;
        stall       = 1'b0;
        br_taken    = 1'b0;
        mret_e      = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_mtime", mtime, 32'd0);
        check("rst_req", intr_req, 1'b0);
        check("rst_hold", hold_fetch, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_active", irq_active, 1'b0);
        check("rst_cause", intr_cause, 32'd0);
        check("rst_epc", epc, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("idle_mtime5", mtime, 32'd5);
        check("idle_hold", hold_fetch, 1'b0);

        // Timer trap at mtimecmp=20
        cmp_wr      = 1'b1;
        cmp_wdata   = 32'd20;
        mstatus_mie = 1'b1;
        mie_meie    = 1'b1;
        mie_mtie    = 1'b1;
        valid_d     = 1'b1;
        pc_d        = 32'h0000_1000;
        tick();
        cmp_wr = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("tmr_mtime20", mtime, 32'd20);
        check("tmr_hold_at20", hold_fetch, 1'b0);
        tick();
        check("tmr_hold_at21", hold_fetch, 1'b1);
        check("tmr_req_at21", intr_req, 1'b0);
        tick();
        check("tmr_req", intr_req, 1'b1);
        check("tmr_flush", flush, 1'b1);
        check("tmr_hold_trap", hold_fetch, 1'b0);
        check("tmr_cause", intr_cause, 32'h8000_0007);
        check("tmr_epc", epc, 32'h0000_1000);
        tick();
        check("tmr_req_off", intr_req, 1'b0);
        check("tmr_active", irq_active, 1'b1);
        check("tmr_flush_off", flush, 1'b0);
        finish_handler();

        // External beats timer; strobe absent during the synchroniser delay
        cmp_wr    = 1'b1;
        cmp_wdata = 32'd0;
        tick();
        cmp_wr      = 1'b0;
        mstatus_mie = 1'b1;
        ext_irq     = 1'b1;
        valid_d     = 1'b0;
        tick();
        check("ext_req_c1", intr_req, 1'b0);
        check("ext_hold_c1", hold_fetch, 1'b1);
        tick();
        check("ext_req_c2", intr_req, 1'b0);
        valid_d = 1'b1;
        pc_d    = 32'h0000_2000;
        tick();
        check("ext_req", intr_req, 1'b1);
        check("ext_cause", intr_cause, 32'h8000_000B);
        check("ext_epc", epc, 32'h0000_2000);
        tick();
        check("ext_active", irq_active, 1'b1);
        finish_handler();

        // Stall for three cycles, then a branch, then the slot opens
        mie_meie    = 1'b0;
        stall       = 1'b1;
        pc_d        = 32'h0000_3000;
        mstatus_mie = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_hold", hold_fetch, 1'b1);
            check("stl_req", intr_req, 1'b0);
        end
        stall    = 1'b0;
        br_taken = 1'b1;
        pc_d     = 32'h0000_3004;
        tick();
        check("br_hold", hold_fetch, 1'b1);
        check("br_req", intr_req, 1'b0);
        br_taken = 1'b0;
        pc_d     = 32'h0000_3008;
        tick();
        check("slot_req", intr_req, 1'b1);
        check("slot_epc", epc, 32'h0000_3008);
        check("slot_cause", intr_cause, 32'h8000_0007);
        tick();
        check("slot_active", irq_active, 1'b1);

        // No nesting in HANDLER; mret with timer pending re-traps after 1 IDLE cycle
        mie_meie = 1'b1;
        ext_irq  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nest_req", intr_req, 1'b0);
            check("nest_active", irq_active, 1'b1);
        end
        ext_irq = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("nest_req_drain", intr_req, 1'b0);
        mie_meie = 1'b0;
        mret_e   = 1'b1;
        tick();
        mret_e = 1'b0;
        check("mret_active", irq_active, 1'b0);
        check("mret_idle_hold", hold_fetch, 1'b0);
        check("mret_idle_req", intr_req, 1'b0);
        tick();
        check("retrap_hold", hold_fetch, 1'b1);
        tick();
        check("retrap_req", intr_req, 1'b1);
        check("retrap_cause", intr_cause, 32'h8000_0007);
        tick();
        finish_handler();

        // Pending withdrawn in WAIT_SLOT
        valid_d     = 1'b0;
        mstatus_mie = 1'b1;
        tick();
        check("wd_hold_wait", hold_fetch, 1'b1);
        mstatus_mie = 1'b0;
        tick();
        check("wd_hold_idle", hold_fetch, 1'b0);
        check("wd_req", intr_req, 1'b0);
        mret_e = 1'b1;
        tick();
        mret_e = 1'b0;
        check("mret_outside_active", irq_active, 1'b0);
        check("mret_outside_req", intr_req, 1'b0);

        // Reset during TRAP drops the strobe
        valid_d     = 1'b1;
        pc_d        = 32'h0000_4000;
        mstatus_mie = 1'b1;
        tick();
        check("rtrap_wait", hold_fetch, 1'b1);
        tick();
        check("rtrap_req", intr_req, 1'b1);
        reset = 1'b1;
        tick();
        check("rtrap_req_off", intr_req, 1'b0);
        check("rtrap_flush_off", flush, 1'b0);
        check("rtrap_hold_off", hold_fetch, 1'b0);
        check("rtrap_active_off", irq_active, 1'b0);
        check("rtrap_mtime", mtime, 32'd0);
        check("rtrap_epc", epc, 32'd0);
        reset       = 1'b0;
        mstatus_mie = 1'b0;
        tick();
        check("rtrap_mtime1", mtime, 32'd1);

        // mtime wrap with mtimecmp=3 on the second instance; hold_fetch in
        // cycle t mirrors tmr_pend in cycle t-1 because valid_d stays low.
        tick();
        check("wrap_mtime0", w_mtime, 32'hFFFF_FFFC);
        w_reset     = 1'b0;
        w_cmp_wr    = 1'b1;
        w_cmp_wdata = 32'd3;
        tick();
        w_cmp_wr = 1'b0;
        check("wrap_hold_w1", w_hold_fetch, 1'b0);
        exp_hold = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            tick();
            check("wrap_mtime", w_mtime, 32'hFFFF_FFFE + 32'(i));
            check("wrap_hold", w_hold_fetch, exp_hold[i]);
        end
        check("wrap_req", w_intr_req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
